keypad_scanner: RTL



---
 rtl/kp_pkg.sv | 31 +++
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/kp_fifo.sv | 54 +++++
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Frame bit 4*col+row maps to a key; KEY_MAP turns that bit index into the printed hex code.
package kp_pkg;

  typedef enum logic {ARMED = 1'b0, HELD = 1'b1} kp_state_t;

  // Indexed by frame bit 4*col+row (column-major over the Pmod KYPD layout).
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  // Returns {valid, idx}: valid only when exactly one bit of img is set.
  function automatic logic [4:0] onehot_index(input logic [15:0] img);
    logic [4:0] res;
    int         n;
    res = '0;
    n   = 0;
    for (int i = 0; i < 16; i++) begin
      if (img[i]) begin
        n        = n + 1;
        res[3:0] = 4'(i);
      end
    end
    res[4] = (n == 1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the MMIO-side key queue signals of the keypad scanner.
// The scanner uses the slave modport; the host/pin side uses master.
interface keypad_scanner_if;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  logic       rd_en;
  logic       ovf_clr;
  logic [3:0] key_code;
  logic       key_avail;
  logic       fifo_full;
  logic       overflow;
  logic       key_down;
  logic       multi_key;

  modport master (
    output kp_row, rd_en, ovf_clr,
    input  kp_col, key_code, key_avail, fifo_full, overflow, key_down, multi_key
  );

  modport slave (
    input  kp_row, rd_en, ovf_clr,
    output kp_col, key_code, key_avail, fifo_full, overflow, key_down, multi_key
  );
endinterface

// File: rtl/kp_fifo.sv
// Small key-code FIFO; the head is read straight from storage so it tracks push/pop one cycle later.
// A pop on empty is ignored; a push on full only lands when a pop frees a slot in the same cycle.
module kp_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_7seg,
  input  logic          Rst,
  input  logic          i_push,
  input  logic [3:0]    i_din,
  input  logic          i_pop,
  output logic [3:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      // NOTE: storage is only a few flops, so it is reset to keep key_code at 0 out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner on clk_7seg: syncs rows, assembles full-matrix frames,
// debounces whole frames and queues single-key press codes for the MMIO read path.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SETTLE     = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_7seg,
  input  logic             Rst,
  keypad_scanner_if.slave  kp_bus
);

  localparam int DW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SW  = $clog2(DEBOUNCE + 1);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [1:0]    r_col;
  logic [DW-1:0] r_dwell;
  logic [15:0]   r_frame, r_prev_frame;
  logic [SW-1:0] r_stable_cnt;
  kp_state_t     r_state;
  logic          r_push;
  logic [3:0]    r_push_code;
  logic          r_key_down, r_multi_key, r_overflow;

  logic [3:0]    w_rows;
  logic          w_sample, w_frame_done, w_accept, w_drop;
  logic [15:0]   w_frame;
  logic [SW-1:0] w_cnt_nxt;
  logic [4:0]    w_onehot;
  logic [3:0]    w_head;
  logic          w_full, w_empty;
  logic [FAW:0]  w_count;

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= kp_bus.kp_row;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_rows       = ~r_row_s2;
  assign w_sample     = (r_dwell == DW'(SETTLE - 1));
  assign w_frame_done = w_sample && (r_col == 2'd3);

  // Frame as it will look once the current column is written in.
  always_comb begin
    // NOTE: default first so the partial update below can never infer a latch.
    w_frame = r_frame;
    w_frame[{r_col, 2'b00} +: 4] = w_rows;
  end

  assign w_cnt_nxt = (w_frame != r_prev_frame)            ? '0 :
                     (r_stable_cnt == SW'(DEBOUNCE - 1))  ? r_stable_cnt :
                                                            r_stable_cnt + 1'b1;
  assign w_accept  = w_frame_done && (w_cnt_nxt == SW'(DEBOUNCE - 1));
  assign w_onehot  = onehot_index(w_frame);
  assign w_drop    = r_push && !kp_bus.rd_en && (w_count == (FAW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      r_col   <= '0;
      r_dwell <= '0;
      r_frame <= '0;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_col   <= r_col + 1'b1;
      r_frame <= w_frame;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Debounce and press FSM: the FSM only moves when a debounced image is accepted.
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      r_prev_frame <= '0;
      r_stable_cnt <= '0;
      r_state      <= ARMED;
      r_push       <= 1'b0;
      r_push_code  <= '0;
      r_key_down   <= 1'b0;
      r_multi_key  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (w_frame_done) begin
        r_prev_frame <= w_frame;
        r_stable_cnt <= w_cnt_nxt;
        if (w_accept) begin
          r_key_down  <= |w_frame;
          r_multi_key <= ($countones(w_frame) > 1);
          case (r_state)
            ARMED: begin
              if (w_onehot[4]) begin
                r_push      <= 1'b1;
                r_push_code <= KEY_MAP[w_onehot[3:0]];
                r_state     <= HELD;
              end else if (|w_frame) begin
                r_state <= HELD;
              end
            end
            HELD:    if (w_frame == '0) r_state <= ARMED;
            default: r_state <= ARMED;
          endcase
        end
      end
      if (w_drop)              r_overflow <= 1'b1;
      else if (kp_bus.ovf_clr) r_overflow <= 1'b0;
    end
  end

  kp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_7seg (clk_7seg),
    .Rst      (Rst),
    .i_push   (r_push),
    .i_din    (r_push_code),
    .i_pop    (kp_bus.rd_en),
    .o_dout   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  assign kp_bus.kp_col    = ~(4'b0001 << r_col);
  assign kp_bus.key_code  = w_head;
  assign kp_bus.key_avail = ~w_empty;
  assign kp_bus.fifo_full = w_full;
  assign kp_bus.overflow  = r_overflow;
  assign kp_bus.key_down  = r_key_down;
  assign kp_bus.multi_key = r_multi_key;

endmodule
